fmap_stream_reader: RTL and testbench

//  Consumer end of the conv layer's packed feature-map bus. It waits for a rising edge on feat_done,

---
 rtl/neuro_pkg.sv | 25 ++
 rtl/fmap_idx_counter.sv | 52 +++++
 rtl/fmap_stream_reader.sv | 129 ++++++++++++
 tb/tb_fmap_stream_reader.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuro_pkg.sv
// rtl/neuro_pkg.sv - shared feature-map geometry, reader states and flat-index helper
package neuro_pkg;

  localparam int FMAP_CH    = 32;
  localparam int FMAP_ROWS  = 13;
  localparam int FMAP_COLS  = 13;
  localparam int FEAT_W     = 8;

  localparam int FMAP_CH_W  = $clog2(FMAP_CH);
  localparam int FMAP_ROW_W = $clog2(FMAP_ROWS);
  localparam int FMAP_COL_W = $clog2(FMAP_COLS);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE,
    WAIT
  } fmap_rd_state_t;

  // Element (c,r,k) position in the packed bus, in units of elements
  function automatic int fmap_flat_idx(input int c, input int r, input int k);
    return (c * FMAP_ROWS + r) * FMAP_COLS + k;
  endfunction

endpackage

// File: rtl/fmap_idx_counter.sv
// rtl/fmap_idx_counter.sv - nested col/row/chan counter, col fastest
module fmap_idx_counter
  import neuro_pkg::*;
#(
  parameter int CHANNELS = FMAP_CH,
  parameter int ROWS     = FMAP_ROWS,
  parameter int COLS     = FMAP_COLS,
  parameter int CH_W     = FMAP_CH_W,
  parameter int ROW_W    = FMAP_ROW_W,
  parameter int COL_W    = FMAP_COL_W
)(
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic [CH_W-1:0]  chan,
  output logic             last_elem
);

  logic col_max;
  logic row_max;
  logic chan_max;

  assign col_max   = (col  == COL_W'(COLS - 1));
  assign row_max   = (row  == ROW_W'(ROWS - 1));
  assign chan_max  = (chan == CH_W'(CHANNELS - 1));
  assign last_elem = col_max && row_max && chan_max;

  // Advance one element per inc, carrying col into row and row into chan
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      col  <= '0;
      row  <= '0;
      chan <= '0;
    end else if (inc) begin
      if (!col_max) begin
        col <= col + COL_W'(1);
      end else begin
        col <= '0;
        if (!row_max) begin
          row <= row + ROW_W'(1);
        end else begin
          row  <= '0;
          chan <= chan_max ? '0 : chan + CH_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/fmap_stream_reader.sv
// rtl/fmap_stream_reader.sv - streams a packed feature map as tagged elements; FMAP_STREAM_LAST_EN adds out_last
module fmap_stream_reader
  import neuro_pkg::*;
#(
  parameter int DATA_W   = FEAT_W,
  parameter int CHANNELS = FMAP_CH,
  parameter int ROWS     = FMAP_ROWS,
  parameter int COLS     = FMAP_COLS,
  localparam int BUS_W   = DATA_W * CHANNELS * ROWS * COLS
)(
  input  logic                        clock,
  input  logic                        reset,
  input  logic [BUS_W-1:0]            feat_bus,
  input  logic                        feat_done,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic [$clog2(CHANNELS)-1:0] out_chan,
  output logic [$clog2(ROWS)-1:0]     out_row,
  output logic [$clog2(COLS)-1:0]     out_col,
  output logic                        busy,
`ifdef FMAP_STREAM_LAST_EN
  output logic                        out_last,
`endif
  output logic                        frame_done
);

  localparam int CH_W   = $clog2(CHANNELS);
  localparam int ROW_W  = $clog2(ROWS);
  localparam int COL_W  = $clog2(COLS);
  localparam int BIT_IW = $clog2(BUS_W);

  fmap_rd_state_t    state;
  fmap_rd_state_t    state_nx;
  logic              done_q;
  logic              rise;
  logic              cnt_clr;
  logic              cnt_inc;
  logic              last_elem;
  int                flat;
  logic [BIT_IW-1:0] bit_base;

  assign rise = feat_done && !done_q;

  // State register and feat_done history for edge detection
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= feat_done;
    end
  end

  // Next state and counter control; a dropped feat_done aborts ahead of any accept
  always_comb begin
    state_nx   = state;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nx = STREAM;
          cnt_clr  = 1'b1;
        end
      end
      STREAM: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (!feat_done) begin
          state_nx = IDLE;
          cnt_clr  = 1'b1;
        end else if (out_ready) begin
          cnt_inc = 1'b1;
          if (last_elem) begin
            state_nx = DONE;
          end
        end
      end
      DONE: begin
        frame_done = 1'b1;
        state_nx   = WAIT;
      end
      WAIT: begin
        if (!feat_done) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  fmap_idx_counter #(
    .CHANNELS (CHANNELS),
    .ROWS     (ROWS),
    .COLS     (COLS),
    .CH_W     (CH_W),
    .ROW_W    (ROW_W),
    .COL_W    (COL_W)
  ) u_idx (
    .clock     (clock),
    .reset     (reset),
    .clr       (cnt_clr),
    .inc       (cnt_inc),
    .col       (out_col),
    .row       (out_row),
    .chan      (out_chan),
    .last_elem (last_elem)
  );

  // Bus mux at the current tags; zero whenever no element is offered
  always_comb begin
    flat     = (int'(out_chan) * ROWS + int'(out_row)) * COLS + int'(out_col);
    bit_base = BIT_IW'(flat * DATA_W);
    out_data = '0;
    if (out_valid) begin
      out_data = feat_bus[bit_base +: DATA_W];
    end
  end

`ifdef FMAP_STREAM_LAST_EN
  assign out_last = out_valid && (out_row == ROW_W'(ROWS - 1)) && (out_col == COL_W'(COLS - 1));
`endif

endmodule

// File: tb/tb_fmap_stream_reader.sv
// tb/tb_fmap_stream_reader.sv - scoreboard bench for fmap_stream_reader
module tb_fmap_stream_reader;
  import neuro_pkg::*;

  localparam int BUS_W = FEAT_W * FMAP_CH * FMAP_ROWS * FMAP_COLS;
  localparam int NELEM = FMAP_CH * FMAP_ROWS * FMAP_COLS;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [BUS_W-1:0] feat_bus = '0;
  logic             feat_done = 1'b0;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [7:0]       out_data;
  logic [4:0]       out_chan;
  logic [3:0]       out_row;
  logic [3:0]       out_col;
  logic             busy;
  logic             frame_done;
`ifdef FMAP_STREAM_LAST_EN
  logic             out_last;
`endif

  fmap_stream_reader dut (
    .clock      (clock),
    .reset      (reset),
    .feat_bus   (feat_bus),
    .feat_done  (feat_done),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_chan   (out_chan),
    .out_row    (out_row),
    .out_col    (out_col),
    .busy       (busy),
`ifdef FMAP_STREAM_LAST_EN
    .out_last   (out_last),
`endif
    .frame_done (frame_done)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] d;
    logic [4:0] c;
    logic [3:0] r;
    logic [3:0] k;
    logic       l;
  } exp_t;

  exp_t sb[$];
  int   checks    = 0;
  int   errors    = 0;
  int   acc_cnt   = 0;
  int   fd_cnt    = 0;
  int   last_cnt  = 0;
  bit   rnd_ready = 1'b0;
  bit   neg_first = 1'b0;
  bit   hold_pend = 1'b0;
  exp_t hold_v;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] elem_val(input int c, input int r, input int k);
    if (neg_first && c == 0 && r == 0 && k == 0) return 8'h80;
    return 8'(c + r + k);
  endfunction

  task automatic load_frame();
    exp_t e;
    for (int c = 0; c < FMAP_CH; c++)
      for (int r = 0; r < FMAP_ROWS; r++)
        for (int k = 0; k < FMAP_COLS; k++) begin
          feat_bus[fmap_flat_idx(c, r, k) * FEAT_W +: FEAT_W] = elem_val(c, r, k);
          e.d = elem_val(c, r, k);
          e.c = 5'(c);
          e.r = 4'(r);
          e.k = 4'(k);
          e.l = (r == FMAP_ROWS - 1) && (k == FMAP_COLS - 1);
          sb.push_back(e);
        end
  endtask

  // Called at posedge+1 with feat_done low for at least the previous edge
  task automatic start_frame(input string name);
    acc_cnt  = 0;
    last_cnt = 0;
    feat_done = 1'b1;
    chk({name, "_pre_valid"}, out_valid, 1'b0);
    @(posedge clock); #1;
    chk({name, "_lat_valid"}, out_valid, 1'b1);
    chk({name, "_first_tags"}, {out_chan, out_row, out_col}, 13'd0);
  endtask

  task automatic wait_frame(input string name);
    int start;
    int n;
    start = fd_cnt;
    n = 0;
    while (fd_cnt == start && n < 20000) begin
      @(posedge clock); #1;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    chk({name, "_frame_done_seen"}, fd_cnt, start + 1);
    chk({name, "_sb_empty"}, sb.size(), 0);
    chk({name, "_count"}, acc_cnt, NELEM);
    chk({name, "_fd_one_cycle"}, frame_done, 1'b0);
    chk({name, "_busy_after"}, busy, 1'b0);
`ifdef FMAP_STREAM_LAST_EN
    chk({name, "_last_pulses"}, last_cnt, FMAP_CH);
`endif
    out_ready = 1'b1;
  endtask

  // Monitor: compare each delivered element against the scoreboard, and stall stability
  always @(negedge clock) begin
    if (!reset && feat_done && out_valid) begin
      if (hold_pend)
        chk("stable", {out_data, out_chan, out_row, out_col}, {hold_v.d, hold_v.c, hold_v.r, hold_v.k});
      if (out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_elem: got %0h expected none", {out_data, out_chan, out_row, out_col});
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("elem", {out_data, out_chan, out_row, out_col}, {e.d, e.c, e.r, e.k});
`ifdef FMAP_STREAM_LAST_EN
          chk("last", out_last, e.l);
          if (out_last) last_cnt++;
`endif
        end
        acc_cnt++;
        hold_pend = 1'b0;
      end else begin
        hold_pend = 1'b1;
        hold_v = {out_data, out_chan, out_row, out_col, 1'b0};
      end
    end else begin
      hold_pend = 1'b0;
    end
    if (!out_valid) chk("data_gated", out_data, 8'h00);
    if (frame_done) fd_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int fd_before;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_fd", frame_done, 1'b0);
    chk("rst_data", out_data, 8'h00);
    chk("rst_tags", {out_chan, out_row, out_col}, 13'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    // T1: full rate frame
    load_frame();
    out_ready = 1'b1;
    start_frame("t1");
    chk("t1_first_data", out_data, 8'h00);
    wait_frame("t1");

    // T2: random backpressure
    feat_done = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    load_frame();
    rnd_ready = 1'b1;
    start_frame("t2");
    wait_frame("t2");
    rnd_ready = 1'b0;
    out_ready = 1'b1;

    // T3: done held high, no replay; then a one-cycle drop re-arms
    fd_before = fd_cnt;
    feat_done = 1'b0;
    @(posedge clock); #1;
    load_frame();
    start_frame("t3a");
    wait_frame("t3a");
    fd_before = fd_cnt;
    repeat (10000) @(posedge clock);
    #1;
    chk("t3_no_replay_fd", fd_cnt, fd_before);
    chk("t3_no_replay_valid", out_valid, 1'b0);
    chk("t3_no_replay_busy", busy, 1'b0);
    feat_done = 1'b0;
    @(posedge clock); #1;
    load_frame();
    start_frame("t3b");
    wait_frame("t3b");

    // T4: abort after 100 accepts
    feat_done = 1'b0;
    @(posedge clock); #1;
    load_frame();
    start_frame("t4a");
    n = 0;
    while (acc_cnt < 100 && n < 1000) begin
      @(posedge clock);
      n++;
    end
    #1;
    chk("t4_accepts", acc_cnt, 100);
    chk("t4_pending_tags", {out_chan, out_row, out_col}, {5'd0, 4'd7, 4'd9});
    chk("t4_pending_data", out_data, 8'd16);
    fd_before = fd_cnt;
    feat_done = 1'b0;
    @(posedge clock); #1;
    chk("t4_abort_valid", out_valid, 1'b0);
    chk("t4_abort_busy", busy, 1'b0);
    chk("t4_abort_tags", {out_chan, out_row, out_col}, 13'd0);
    sb.delete();
    repeat (3) @(posedge clock);
    #1;
    chk("t4_no_fd", fd_cnt, fd_before);
    load_frame();
    start_frame("t4b");
    wait_frame("t4b");

    // T5: reset mid-frame, then a frame whose first element is 8'h80
    feat_done = 1'b0;
    @(posedge clock); #1;
    neg_first = 1'b1;
    load_frame();
    start_frame("t5a");
    n = 0;
    while (acc_cnt < 50 && n < 1000) begin
      @(posedge clock);
      n++;
    end
    #1;
    reset = 1'b1;
    feat_done = 1'b0;
    @(posedge clock); #1;
    chk("t5_rst_valid", out_valid, 1'b0);
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_fd", frame_done, 1'b0);
    chk("t5_rst_data", out_data, 8'h00);
    chk("t5_rst_tags", {out_chan, out_row, out_col}, 13'd0);
    reset = 1'b0;
    sb.delete();
    repeat (20) @(posedge clock);
    #1;
    chk("t5_idle_valid", out_valid, 1'b0);
    chk("t5_idle_busy", busy, 1'b0);
    load_frame();
    start_frame("t5b");
    chk("t5_signed_min", ($signed(out_data) == -128), 1'b1);
    wait_frame("t5b");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
